// File: rtl/text_pkg.sv
// text_pkg: shared constants, FSM state type and the glyph table
// for the text character source.
package text_pkg;

  localparam int TEXT_ADDR_W = 12;
  localparam int TEXT_CODE_W = 7;
  localparam int TEXT_LINE_W = 4;
  localparam int TEXT_CELLS  = 4096;
  localparam int FONT_AW     = TEXT_CODE_W + TEXT_LINE_W;

  localparam logic [TEXT_CODE_W-1:0] CLEAR_CODE = 7'h20;

  localparam int unsigned TEXT_BLINK_DIV = 32_500_000;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } text_fsm_t;

  // Space, control codes and DEL are blank. Printable codes without
  // a drawn glyph render as a hollow box so they stay visible.
  function automatic logic [7:0] font_row(
    input logic [TEXT_CODE_W-1:0] code,
    input logic [TEXT_LINE_W-1:0] line
  );
    logic [7:0] r;
    r = 8'h00;
    if (code > 7'h20 && code != 7'h7F) begin
      case (code)
        7'h41: begin
          case (line)
            4'd2:    r = 8'h10;
            4'd3:    r = 8'h38;
            4'd4:    r = 8'h6C;
            4'd5,
            4'd6:    r = 8'hC6;
            4'd7:    r = 8'hFE;
            4'd8,
            4'd9,
            4'd10,
            4'd11:   r = 8'hC6;
            default: r = 8'h00;
          endcase
        end
        7'h42: begin
          case (line)
            4'd2:    r = 8'hFC;
            4'd3,
            4'd4,
            4'd5:    r = 8'h66;
            4'd6:    r = 8'h7C;
            4'd7,
            4'd8,
            4'd9,
            4'd10:   r = 8'h66;
            4'd11:   r = 8'hFC;
            default: r = 8'h00;
          endcase
        end
        default: begin
          case (line)
            4'd2,
            4'd11:   r = 8'h7E;
            4'd3,
            4'd4,
            4'd5,
            4'd6,
            4'd7,
            4'd8,
            4'd9,
            4'd10:   r = 8'h42;
            default: r = 8'h00;
          endcase
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/font_rom.sv
// font_rom: 2048x8 synchronous glyph ROM, one-cycle registered output.
// Ports: clk, rst_n (async, low), addr_i = {code, line}, data_o = row.
module font_rom
  import text_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FONT_AW-1:0] addr_i,
  output logic [7:0]         data_o
);

  logic [7:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
    end else begin
      data_q <= font_row(addr_i[FONT_AW-1:TEXT_LINE_W],
                         addr_i[TEXT_LINE_W-1:0]);
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/text_char_source.sv
// text_char_source: 4096-cell text buffer with clear sweep and a
// 2-cycle char_xy/char_line -> char_pixels glyph fetch path.
// Ports: clk, rst_n (async, low); char_xy, char_line -> char_pixels;
// write port wr_valid/wr_ready/wr_addr/wr_code; clr_req, busy;
// cursor_addr only when TEXT_CURSOR_EN is defined (blinking cursor).
module text_char_source
  import text_pkg::*;
`ifdef TEXT_CURSOR_EN
#(
  parameter int unsigned BLINK_DIV = TEXT_BLINK_DIV
)
`endif
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TEXT_ADDR_W-1:0] char_xy,
  input  logic [TEXT_LINE_W-1:0] char_line,
  output logic [7:0]             char_pixels,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [TEXT_ADDR_W-1:0] wr_addr,
  input  logic [TEXT_CODE_W-1:0] wr_code,
  input  logic                   clr_req,
  output logic                   busy
`ifdef TEXT_CURSOR_EN
  ,
  input  logic [TEXT_ADDR_W-1:0] cursor_addr
`endif
);

  text_fsm_t              state_q, state_d;
  logic [TEXT_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [TEXT_CODE_W-1:0] mem [TEXT_CELLS];
  logic                   mem_we;
  logic [TEXT_ADDR_W-1:0] mem_waddr;
  logic [TEXT_CODE_W-1:0] mem_wdata;

  logic [TEXT_CODE_W-1:0] code_q;
  logic [TEXT_LINE_W-1:0] line_q;
  logic [7:0]             rom_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // A clr_req in IDLE blocks the write of that cycle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_code;
    case (state_q)
      ST_IDLE: begin
        wr_ready = !clr_req;
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (wr_valid) begin
          mem_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLEAR_CODE;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == TEXT_ADDR_W'(TEXT_CELLS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Buffer RAM and stage-1 read register; no reset so it maps to
  // block RAM. The read register sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    code_q <= mem[char_xy];
    line_q <= char_line;
  end

  font_rom u_font_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i ({code_q, line_q}),
    .data_o (rom_data)
  );

`ifdef TEXT_CURSOR_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   phase_q, phase_d;
  logic                   inv_q, inv_d;
  logic [TEXT_ADDR_W-1:0] xy_q;

  always_ff @(posedge clk) begin
    xy_q <= char_xy;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    inv_d = phase_q && (xy_q == cursor_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      inv_q       <= inv_d;
    end
  end

  assign char_pixels = rom_data ^ {8{inv_q}};
`else
  assign char_pixels = rom_data;
`endif

endmodule

// File: tb/tb_text_char_source.sv
// tb_text_char_source: vector table plus scoreboard bench for the
// text character source, including clear/reset corner sequences.
module tb_text_char_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [6:0]  wr_code;
  logic        clr_req;
  logic        busy;
  logic [11:0] cursor_addr;

  always #5 clk = ~clk;

`ifdef TEXT_CURSOR_EN
  text_char_source #(.BLINK_DIV(8)) dut (
`else
  text_char_source dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .char_xy     (char_xy),
    .char_line   (char_line),
    .char_pixels (char_pixels),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_code     (wr_code),
    .clr_req     (clr_req)
`ifdef TEXT_CURSOR_EN
    ,
    .busy        (busy),
    .cursor_addr (cursor_addr)
`else
    ,
    .busy        (busy)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38,
                               8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6,
                               8'h00, 8'h00, 8'h00, 8'h00};

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  typedef struct {
    logic [11:0] xy;
    logic [3:0]  ln;
    logic [7:0]  exp;
    string       tag;
  } vec_t;

  exp_t sbq[$];
  vec_t vec[17];

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk(e.tag, {24'h0, char_pixels}, {24'h0, e.exp});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] xy, input logic [3:0] ln,
                    input logic [7:0] e, input string tag);
    char_xy   = xy;
    char_line = ln;
    sbq.push_back('{cyc + 2, e, tag});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    step();
    if (sbq.size() != 0) begin
      chk("drain", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [6:0] c);
    int n;
    wr_addr  = a;
    wr_code  = c;
    wr_valid = 1'b1;
    #1;
    n = 0;
    while (!wr_ready && n < 10) begin
      step();
      n++;
    end
    chk("wr_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic sweep_len(input int start_hi, input int pulse_at,
                           input string tag);
    int hi;
    int n;
    hi = start_hi;
    n  = 0;
    while (n < 5000) begin
      clr_req = (hi == pulse_at);
      step();
      n++;
      if (busy) hi++;
      else break;
    end
    clr_req = 1'b0;
    chk(tag, hi, 4096);
  endtask

  initial begin
    logic [7:0] s [48];
    int f;
    int ok;
    int bad;

    rst_n       = 1'b0;
    char_xy     = '0;
    char_line   = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_code     = '0;
    clr_req     = 1'b0;
    cursor_addr = 12'h105;

    vec[0] = '{12'h3A7, 4'd5, 8'h00, "blank_3A7"};
    for (int i = 0; i < 16; i++) begin
      vec[1 + i] = '{12'h105, 4'(i), glyph_a[i], "glyph_A"};
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixels", char_pixels, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 1);

    @(negedge clk);
    rst_n = 1'b1;
    sweep_len(busy, -1, "init_sweep_len");
    chk("init_ready", wr_ready, 1);

    wr(12'h105, 7'h41);
    for (int i = 0; i < 17; i++) begin
      rd(vec[i].xy, vec[i].ln, vec[i].exp, vec[i].tag);
      step();
    end
    drain();

    wr(12'h010, 7'h41);
    wr_valid = 1'b1;
    wr_addr  = 12'h010;
    wr_code  = 7'h42;
    rd(12'h010, 4'd3, 8'h38, "rdw_old");
    step();
    wr_valid = 1'b0;
    rd(12'h010, 4'd3, 8'h66, "rdw_new");
    step();
    drain();

    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 12'h020;
    wr_code  = 7'h42;
    #1;
    chk("clr_wins_ready", wr_ready, 0);
    step();
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    sweep_len(busy, 100, "clr_sweep_len");
    chk("clr_ready", wr_ready, 1);
    rd(12'h020, 4'd3, 8'h00, "clr_no_write");
    step();
    rd(12'h105, 4'd3, 8'h00, "clr_swept_105");
    step();
    drain();

    wr(12'hF00, 7'h41);
    char_xy   = 12'hF00;
    char_line = 4'd3;
    clr_req   = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (2000) step();
    chk("pre_reset_pix", char_pixels, 8'h38);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pixels", char_pixels, 0);
    chk("mid_rst_ready", wr_ready, 0);
    chk("mid_rst_busy", busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_len(busy, -1, "restart_sweep_len");
    chk("restart_ready", wr_ready, 1);
    chk("restart_F00", char_pixels, 0);
    rd(12'h3A7, 4'd5, 8'h00, "post_rst_blank");
    step();
    drain();

`ifdef TEXT_CURSOR_EN
    wr(12'h105, 7'h41);
    char_xy   = 12'h105;
    char_line = 4'd3;
    repeat (3) step();
    for (int k = 0; k < 48; k++) begin
      s[k] = char_pixels;
      step();
    end
    ok = 1;
    f  = -1;
    for (int k = 0; k < 48; k++) begin
      if (s[k] != 8'h38 && s[k] != 8'hC7) ok = 0;
    end
    for (int k = 1; k < 48; k++) begin
      if (f < 0 && s[k] != s[k-1]) f = k;
    end
    if (f < 0 || f > 8) ok = 0;
    else begin
      for (int k = f + 1; k < 48; k++) begin
        if ((s[k] != s[k-1]) != ((k - f) % 8 == 0)) ok = 0;
      end
    end
    chk("cursor_blink", ok, 1);
    char_xy = 12'h104;
    repeat (3) step();
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (char_pixels != 8'h00) bad++;
      step();
    end
    chk("cursor_other_cell", bad, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
